// File: rtl/shift_sched.sv
// Round-robin owner of a shared serial shift_reg lane: each grant exchanges a
// requester's word for the lane's previous contents over WIDTH shift cycles.
module shift_sched #(
  parameter int   NREQ  = 4,
  parameter int   WIDTH = 16,
  localparam int  IDW   = $clog2(NREQ),
  localparam int  CW    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  sr_en,
  output logic                  sr_in,
  input  logic                  sr_out,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  cap_q, cap_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]  wdata_arr [NREQ];
  logic              win_found;
  logic [IDW-1:0]    win_idx;
  int                cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr_q) + off) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    done_id_d = done_id_q;
    gnt_d     = '0;
    shadow_d  = shadow_q;
    cap_d     = cap_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_SHIFT;
          ptr_d          = win_idx;
          id_d           = win_idx;
          gnt_d[win_idx] = 1'b1;
          shadow_d       = wdata_arr[win_idx];
          cnt_d          = '0;
        end
      end
      S_SHIFT: begin
        // Lane emits its old word LSB first, so filling the capture from the
        // top leaves it in original bit order after WIDTH shifts.
        shadow_d = shadow_q >> 1;
        cap_d    = {sr_out, cap_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d   = S_DONE;
          rdata_d   = {sr_out, cap_q[WIDTH-1:1]};
          done_id_d = id_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDW'(NREQ-1);
      id_q      <= '0;
      done_id_q <= '0;
      gnt_q     <= '0;
      shadow_q  <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      done_id_q <= done_id_d;
      gnt_q     <= gnt_d;
      shadow_q  <= shadow_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign sr_en   = (state_q == S_SHIFT);
  assign sr_in   = (state_q == S_SHIFT) & shadow_q[0];
  assign done    = (state_q == S_DONE);
  assign done_id = done_id_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: drives a behavioural lane and checks each exchange
// against a word-level model of the lane contents and round-robin pointer.
module tb_shift_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] wdata = '0;
  logic [3:0]  gnt;
  logic        busy, sr_en, sr_in, sr_out, done;
  logic [1:0]  done_id;
  logic [15:0] rdata;

  shift_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .busy(busy),
    .sr_en(sr_en), .sr_in(sr_in), .sr_out(sr_out), .done(done),
    .done_id(done_id), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // The shared lane: serial in at the top, serial out from bit 0.
  logic [15:0] lane;
  always @(posedge clk or posedge rst) begin
    if (rst) lane <= '0;
    else if (sr_en) lane <= {sr_in, lane[15:1]};
  end
  assign sr_out = lane[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Reference model: what the lane holds and who won last.
  int          m_ptr;
  logic [15:0] m_lane;

  // Observations from one transfer.
  bit          obs_timeout;
  logic [3:0]  obs_gnt, obs_gnt1;
  int          obs_gnt_cyc, obs_en, obs_lat, obs_done_cnt;
  logic        obs_busy0, obs_busy17;
  logic [15:0] obs_rdata;
  logic [1:0]  obs_id;

  function automatic int pick(input int p, input logic [3:0] r);
    for (int o = 1; o <= NREQ; o++) begin
      int c = (p + o) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] w, input int i);
    return w[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr  = NREQ - 1;
    m_lane = '0;
  endtask

  // Drives one request and records what the DUT did; makes no judgement.
  task automatic run_xfer(input logic [3:0] r, input logic [63:0] wd, input bit hold,
                          input bit mid, input logic [3:0] mid_req, input logic [63:0] mid_wd);
    bit got = 0;
    obs_timeout = 0; obs_en = 0; obs_lat = -1; obs_done_cnt = 0;
    obs_gnt = '0; obs_gnt1 = 'x; obs_rdata = 'x; obs_id = 'x;
    req = r;
    wdata = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (gnt !== 4'b0000) got = 1;
    end
    if (!got) begin
      obs_timeout = 1;
      req = '0;
      return;
    end
    obs_gnt = gnt; obs_gnt_cyc = cyc; obs_busy0 = busy;
    if (sr_en === 1'b1) obs_en++;
    if (!hold) req = '0;
    for (int k = 1; k <= 17; k++) begin
      if (mid && k == 3) begin req = mid_req; wdata = mid_wd; end
      if (mid && k == 4) req = hold ? r : 4'b0000;
      tick();
      if (k == 1) obs_gnt1 = gnt;
      if (sr_en === 1'b1) obs_en++;
      if (done === 1'b1) begin
        if (obs_done_cnt == 0) begin obs_lat = k; obs_rdata = rdata; obs_id = done_id; end
        obs_done_cnt++;
      end
      if (k == 17) obs_busy17 = busy;
    end
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    bit got;
    rst = 1'b1;
    tick(); tick(); tick();
    outs = {gnt, busy, sr_en, sr_in, done, done_id, rdata};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_state: got %h want 0", outs); end
    rst = 1'b0;
    wdata = {$urandom, $urandom};
    req = 4'hF;
    got = 0;
    for (int k = 0; k < 5 && !got; k++) begin tick(); if (gnt !== 4'b0000) got = 1; end
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (busy !== 1'b1 || sr_en !== 1'b1) begin bad++; $display("FAIL midshift_busy: got %b%b want 11", busy, sr_en); end
    rst = 1'b1;
    #1;
    outs = {gnt, busy, sr_en, sr_in, done, done_id, rdata};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", outs); end
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL post_reset_gnt: got %b want 0001", gnt); end
    req = '0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); if (done === 1'b1) got = 1; end
    total++;
    if (!got || rdata !== 16'h0000 || done_id !== 2'd0) begin
      bad++; $display("FAIL aborted_lane_cleared: got done=%0d rdata=%h id=%0d want done rdata=0000 id=0", got, rdata, done_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    run_xfer(4'b0100, 64'h0000_A5C3_0000_0000, 0, 0, '0, '0);
    total++;
    if (obs_timeout) begin bad++; $display("FAIL single_timeout: no gnt within bound"); return; end
    total++;
    if (obs_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", obs_gnt); end
    total++;
    if (obs_gnt1 !== 4'b0000 || obs_busy0 !== 1'b1) begin bad++; $display("FAIL single_gnt_pulse: gnt@E1 %b busy@E0 %b want 0000 1", obs_gnt1, obs_busy0); end
    total++;
    if (obs_en != 16) begin bad++; $display("FAIL single_sr_en_cycles: got %0d want 16", obs_en); end
    total++;
    if (obs_lat != 16 || obs_done_cnt != 1) begin bad++; $display("FAIL single_done_timing: lat %0d count %0d want 16 1", obs_lat, obs_done_cnt); end
    total++;
    if (obs_rdata !== 16'h0000 || obs_id !== 2'd2) begin bad++; $display("FAIL single_result: rdata %h id %0d want 0000 2", obs_rdata, obs_id); end
    total++;
    if (obs_busy17 !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", obs_busy17); end
  endtask

  task automatic test_exchange();
    logic [3:0]  rq [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [15:0] wd [3] = '{16'h1234, 16'hBEEF, 16'h0000};
    logic [15:0] er [3] = '{16'h0000, 16'h1234, 16'hBEEF};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] w = '0;
      w[i*16 +: 16] = wd[i];
      run_xfer(rq[i], w, 0, 0, '0, '0);
      total++;
      if (obs_timeout || obs_gnt !== rq[i]) begin bad++; $display("FAIL exchange_gnt[%0d]: got %b want %b", i, obs_gnt, rq[i]); end
      total++;
      if (obs_rdata !== er[i] || obs_id !== 2'(i)) begin bad++; $display("FAIL exchange_rdata[%0d]: rdata %h id %0d want %h %0d", i, obs_rdata, obs_id, er[i], i); end
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 3, 0, 1, 3};
    int prev_cyc = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [63:0] w = {$urandom, $urandom};
      int exp = pick(m_ptr, 4'b1011);
      run_xfer(4'b1011, w, 1, 0, '0, '0);
      total++;
      if (obs_timeout || obs_gnt !== 4'(1 << order[i]) || exp != order[i]) begin
        bad++; $display("FAIL rr_order[%0d]: got %b want %b", i, obs_gnt, 4'(1 << order[i]));
      end
      if (i > 0) begin
        total++;
        if (obs_gnt_cyc - prev_cyc != 18) begin bad++; $display("FAIL rr_period[%0d]: got %0d want 18", i, obs_gnt_cyc - prev_cyc); end
      end
      total++;
      if (obs_rdata !== m_lane || obs_id !== 2'(order[i])) begin bad++; $display("FAIL rr_rdata[%0d]: rdata %h id %0d want %h %0d", i, obs_rdata, obs_id, m_lane, order[i]); end
      prev_cyc = obs_gnt_cyc;
      m_lane = word_of(w, order[i]);
      m_ptr = order[i];
    end
    req = '0;
  endtask

  task automatic test_withdrawal();
    int stray = 0;
    do_reset();
    run_xfer(4'b0100, 64'h0000_7E57_0000_0000, 0, 1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF);
    total++;
    if (obs_timeout || obs_gnt !== 4'b0100 || obs_id !== 2'd2) begin bad++; $display("FAIL withdraw_first: gnt %b id %0d want 0100 2", obs_gnt, obs_id); end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (gnt !== 4'b0000) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL withdraw_no_gnt: got %0d grants want 0", stray); end
    run_xfer(4'b0001, 64'h0, 0, 0, '0, '0);
    total++;
    if (obs_timeout || obs_gnt !== 4'b0001) begin bad++; $display("FAIL wdata_hold_gnt: got %b want 0001", obs_gnt); end
    total++;
    if (obs_rdata !== 16'h7E57) begin bad++; $display("FAIL wdata_hold_word: got %h want 7e57", obs_rdata); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [3:0]  r = 4'($urandom_range(1, 15));
      logic [63:0] w = {$urandom, $urandom};
      bit          m = 1'($urandom_range(0, 1));
      int          exp = pick(m_ptr, r);
      run_xfer(r, w, 0, m, 4'($urandom), {$urandom, $urandom});
      total++;
      if (obs_timeout || obs_gnt !== 4'(1 << exp)) begin bad++; $display("FAIL rand_gnt[%0d]: req %b got %b want %b", i, r, obs_gnt, 4'(1 << exp)); end
      total++;
      if (obs_rdata !== m_lane || obs_id !== 2'(exp)) begin bad++; $display("FAIL rand_rdata[%0d]: rdata %h id %0d want %h %0d", i, obs_rdata, obs_id, m_lane, exp); end
      total++;
      if (obs_en != 16 || obs_lat != 16) begin bad++; $display("FAIL rand_timing[%0d]: en %0d lat %0d want 16 16", i, obs_en, obs_lat); end
      m_lane = word_of(w, exp);
      m_ptr = exp;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_exchange();
    test_round_robin();
    test_withdrawal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
